// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive stages.
//
// Contents:
//   uart_state_e     frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   UART_DATA_BITS   data bits per frame (8)
//   UART_START_LVL   line level of the start bit (0)
//   UART_STOP_LVL    line level of the stop bit (1)
//   UART_IDLE_LVL    line level between frames (1)
//   uart_parity()    parity bit for a byte, even or odd sense
//
// Configuration macro: UART_TX_PARITY_EN (parity bit in the frame),
// supplied by the build; without it frames are 10 bits.

package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b,
                                       input logic odd);
    return odd ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: byte handshake into the UART transmitter.
//
// Signals:
//   tx_data   byte to transmit, sampled on accept
//   tx_valid  producer has a byte on tx_data
//   tx_ready  transmitter holding register is empty
//
// Handshake: a byte transfers on every rising clock edge where
// tx_valid && tx_ready. tx_ready never depends combinationally on
// tx_valid. The producer may drop tx_valid at any time; a byte that has
// not yet been accepted is simply not sent.
//
// Modports: master = byte producer, slave = transmitter.

interface uart_tx_frame_if;

  logic [uart_pkg::UART_DATA_BITS-1:0] tx_data;
  logic                                tx_valid;
  logic                                tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer shared by the UART transmit and
// receive stages.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   restart  hold the count at zero (used while the line is idle so the
//            first bit of a frame starts a full period)
//   tick     high in the last cycle of each bit period
//
// The count runs 0..CLKS_PER_BIT-1 and wraps to 0 after the terminal
// count, so back-to-back bits keep exact spacing without a restart.

module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with a one-byte holding register.
//
// Frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// Each bit lasts CLKS_PER_BIT clocks.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
//   PARITY_ODD    0 = even parity, 1 = odd parity
//
// Ports:
//   clk      clock, rising edge
//   reset    asynchronous active-low reset
//   tx       byte handshake (uart_tx_frame_if.slave): tx_data, tx_valid,
//            tx_ready
//   tx_out   registered serial line, idles high
//   tx_busy  a frame is on the line
//   state    current FSM state (uart_state_e encoding), for observation
//
// Configuration macro: UART_TX_PARITY_EN. When defined, the PARITY state
// is present and frames are 11 bits; otherwise DATA goes straight to
// STOP and frames are 10 bits.

module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_frame_if.slave       tx,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic [2:0]           state
);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] START  = ST_START;
  localparam logic [2:0] DATA   = ST_DATA;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = ST_PARITY;
`endif
  localparam logic [2:0] STOP   = ST_STOP;

  // Holding register: one byte buffered ahead of the shifter.
  logic [UART_DATA_BITS-1:0] hold_data;
  logic                      hold_full;

  // Shifter and bit position within the data field.
  logic [UART_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_idx;

  logic [2:0]                state_d;
  logic [UART_DATA_BITS-1:0] shift_d;
  logic [2:0]                idx_d;
  logic                      out_d;
  logic                      load;
  logic                      accept;
  logic                      bit_end;
  logic                      baud_restart;

`ifdef UART_TX_PARITY_EN
  // Copy of the byte taken at load; the shifter is consumed by the time
  // the parity bit goes out.
  logic [UART_DATA_BITS-1:0] byte_q;
  logic [UART_DATA_BITS-1:0] byte_d;
`endif

  assign tx.tx_ready = !hold_full;
  assign accept      = tx.tx_valid && !hold_full;
  assign tx_busy     = (state != IDLE);

  // Counter parks at zero while idle so every frame starts on a fresh
  // bit period; between back-to-back frames it wraps on its own.
  assign baud_restart = (state == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .reset   (reset),
    .restart (baud_restart),
    .tick    (bit_end)
  );

  // Next-state logic. Outputs are derived from the next state so tx_out
  // can be a plain register with no decode glitches on the line.
  always_comb begin
    state_d = state;
    shift_d = shift_q;
    idx_d   = bit_idx;
    load    = 1'b0;

    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end

      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (bit_idx == 3'd7) begin
            // Index returns to 0 by leaving DATA, never by overflow.
            idx_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = bit_idx + 3'd1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (bit_end) begin
          if (hold_full) begin
            // Chain straight into the next start bit: no idle gap.
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      shift_d = hold_data;
      idx_d   = 3'd0;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    byte_d = byte_q;
    if (load) begin
      byte_d = hold_data;
    end
  end
`endif

  always_comb begin
    out_d = UART_IDLE_LVL;
    case (state_d)
      START:  out_d = UART_START_LVL;
      DATA:   out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY: out_d = uart_parity(byte_d, PARITY_ODD);
`endif
      STOP:   out_d = UART_STOP_LVL;
      default: out_d = UART_IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_q   <= '0;
      bit_idx   <= 3'd0;
      tx_out    <= UART_IDLE_LVL;
      hold_data <= '0;
      hold_full <= 1'b0;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      bit_idx <= idx_d;
      tx_out  <= out_d;

      // Accept wins over load so a byte taken on the same edge as a load
      // stays held. With tx_ready = !hold_full the two cannot coincide,
      // but the priority keeps the register safe if that ever changes.
      if (accept) begin
        hold_data <= tx.tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_q <= '0;
    end else begin
      byte_q <= byte_d;
    end
  end
`else
  // Parity sense has no effect in the 10-bit frame build.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed bench for uart_tx_frame.
// Three instances share clock and reset: 1 clk/bit even parity (dut_e),
// 1 clk/bit odd parity (dut_o), 4 clk/bit even parity (dut_s).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic clk;
  logic reset;

  uart_tx_frame_if if_e ();
  uart_tx_frame_if if_o ();
  uart_tx_frame_if if_s ();

  logic       out_e, busy_e;
  logic       out_o, busy_o;
  logic       out_s, busy_s;
  logic [2:0] st_e, st_o, st_s;

  int total;
  int bad;

  logic [0:0] exp_q[$];

  uart_tx_frame #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b0)) dut_e (
    .clk (clk), .reset (reset), .tx (if_e), .tx_out (out_e), .tx_busy (busy_e), .state (st_e)
  );

  uart_tx_frame #(.CLKS_PER_BIT(1), .PARITY_ODD(1'b1)) dut_o (
    .clk (clk), .reset (reset), .tx (if_o), .tx_out (out_o), .tx_busy (busy_o), .state (st_o)
  );

  uart_tx_frame #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut_s (
    .clk (clk), .reset (reset), .tx (if_s), .tx_out (out_s), .tx_busy (busy_s), .state (st_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- expected frame model ----------------
  function automatic void push_frame(input logic [7:0] b, input logic odd);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(odd ? ~^b : ^b);
`else
    if (odd) exp_q.push_back(1'b1);
    if (odd) void'(exp_q.pop_back());
`endif
    exp_q.push_back(1'b1);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (out_e !== 1'b1) begin bad++; $display("FAIL reset_out: got %b want 1", out_e); end
    total++; if (if_e.tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", if_e.tx_ready); end
    total++; if (busy_e !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy_e); end
    total++; if (st_e !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", st_e); end
    total++; if (out_s !== 1'b1 || busy_s !== 1'b0) begin bad++; $display("FAIL reset_slow: got out=%b busy=%b want 1/0", out_s, busy_s); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out_e !== 1'b1 || busy_e !== 1'b0 || if_e.tx_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset_idle: got out=%b busy=%b rdy=%b want 1/0/1", out_e, busy_e, if_e.tx_ready);
    end
  endtask

  task automatic test_frame_33();
    logic [10:0] exp33;
    int busy_cnt;
`ifdef UART_TX_PARITY_EN
    exp33 = 11'b10001100110;
`else
    exp33 = 11'b01001100110;
`endif
    @(negedge clk); if_e.tx_data = 8'h33; if_e.tx_valid = 1'b1;
    @(negedge clk); if_e.tx_valid = 1'b0;
    total++; if (out_e !== 1'b1 || busy_e !== 1'b0 || if_e.tx_ready !== 1'b0) begin
      bad++; $display("FAIL f33_accept: got out=%b busy=%b rdy=%b want 1/0/0", out_e, busy_e, if_e.tx_ready);
    end
    busy_cnt = 0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (busy_e) busy_cnt++;
      total++; if (out_e !== exp33[i]) begin bad++; $display("FAIL f33_bit%0d: got %b want %b", i, out_e, exp33[i]); end
    end
    @(negedge clk);
    total++; if (out_e !== 1'b1 || busy_e !== 1'b0 || if_e.tx_ready !== 1'b1) begin
      bad++; $display("FAIL f33_end: got out=%b busy=%b rdy=%b want 1/0/1", out_e, busy_e, if_e.tx_ready);
    end
    total++; if (busy_cnt !== FL) begin bad++; $display("FAIL f33_busy_len: got %0d want %0d", busy_cnt, FL); end
  endtask

  task automatic test_parity();
    logic [0:0] e;
    logic [0:0] par_e, par_o;
    exp_q.delete(); push_frame(8'h07, 1'b0);
    @(negedge clk); if_e.tx_data = 8'h07; if_e.tx_valid = 1'b1;
    @(negedge clk); if_e.tx_valid = 1'b0;
    par_e = 1'b0;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (i == 9) par_e = out_e;
      total++; if (out_e !== e) begin bad++; $display("FAIL par_even_bit%0d: got %b want %b", i, out_e, e); end
    end
    exp_q.delete(); push_frame(8'h07, 1'b1);
    @(negedge clk); if_o.tx_data = 8'h07; if_o.tx_valid = 1'b1;
    @(negedge clk); if_o.tx_valid = 1'b0;
    par_o = 1'b1;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (i == 9) par_o = out_o;
      total++; if (out_o !== e) begin bad++; $display("FAIL par_odd_bit%0d: got %b want %b", i, out_o, e); end
    end
    @(negedge clk);
`ifdef UART_TX_PARITY_EN
    total++; if (par_e !== 1'b1) begin bad++; $display("FAIL par_even_07: got %b want 1", par_e); end
    total++; if (par_o !== 1'b0) begin bad++; $display("FAIL par_odd_07: got %b want 0", par_o); end
`endif
    total++; if (out_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("FAIL par_odd_end: got out=%b busy=%b want 1/0", out_o, busy_o); end
  endtask

  task automatic test_back_to_back();
    int n_acc;
    logic will;
    logic [0:0] e;
    logic exp_rdy, exp_busy;
    exp_q.delete(); push_frame(8'hA5, 1'b0); push_frame(8'h5A, 1'b0);
    n_acc = 0;
    @(negedge clk); if_e.tx_data = 8'hA5; if_e.tx_valid = 1'b1;
    for (int k = 0; k <= 2 * FL + 1; k++) begin
      will = if_e.tx_valid && if_e.tx_ready;
      @(negedge clk);
      if (will) begin
        n_acc++;
        if (n_acc == 1) if_e.tx_data = 8'h5A;
        else if_e.tx_valid = 1'b0;
      end
      if (k == 0 || k == 2 * FL + 1) e = 1'b1;
      else e = exp_q.pop_front();
      exp_rdy  = (k == 1) || (k > FL);
      exp_busy = (k >= 1) && (k <= 2 * FL);
      total++; if (out_e !== e) begin bad++; $display("FAIL b2b_out k=%0d: got %b want %b", k, out_e, e); end
      total++; if (if_e.tx_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready k=%0d: got %b want %b", k, if_e.tx_ready, exp_rdy); end
      total++; if (busy_e !== exp_busy) begin bad++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy_e, exp_busy); end
    end
    if_e.tx_valid = 1'b0;
    total++; if (n_acc !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2", n_acc); end
  endtask

  task automatic test_slow_baud();
    logic [0:0] e;
    int busy_cnt;
    logic last_data;
    exp_q.delete(); push_frame(8'h80, 1'b0);
    @(negedge clk); if_s.tx_data = 8'h80; if_s.tx_valid = 1'b1;
    @(negedge clk); if_s.tx_valid = 1'b0;
    total++; if (out_s !== 1'b1) begin bad++; $display("FAIL slow_accept: got %b want 1", out_s); end
    busy_cnt = 0;
    last_data = 1'b0;
    for (int c = 0; c < 4 * FL; c++) begin
      @(negedge clk);
      e = exp_q[c / 4];
      if (busy_s) busy_cnt++;
      if (c == 35) last_data = out_s;
      total++; if (out_s !== e) begin bad++; $display("FAIL slow_cyc%0d: got %b want %b", c, out_s, e); end
    end
    @(negedge clk);
    total++; if (out_s !== 1'b1 || busy_s !== 1'b0) begin bad++; $display("FAIL slow_end: got out=%b busy=%b want 1/0", out_s, busy_s); end
    total++; if (busy_cnt !== 4 * FL) begin bad++; $display("FAIL slow_busy_len: got %0d want %0d", busy_cnt, 4 * FL); end
    total++; if (last_data !== 1'b1) begin bad++; $display("FAIL slow_last_data: got %b want 1", last_data); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); if_e.tx_data = 8'hFF; if_e.tx_valid = 1'b1;
    @(negedge clk); if_e.tx_data = 8'h12;
    @(negedge clk);
    @(negedge clk); if_e.tx_valid = 1'b0;
    total++; if (if_e.tx_ready !== 1'b0) begin bad++; $display("FAIL rst_held: got rdy=%b want 0", if_e.tx_ready); end
    repeat (3) @(negedge clk);
    total++; if (st_e !== 3'd2 || out_e !== 1'b1) begin bad++; $display("FAIL rst_pre: got st=%0d out=%b want 2/1", st_e, out_e); end
    reset = 1'b0;
    #1;
    total++; if (out_e !== 1'b1 || busy_e !== 1'b0 || if_e.tx_ready !== 1'b1 || st_e !== 3'd0) begin
      bad++; $display("FAIL rst_async: got out=%b busy=%b rdy=%b st=%0d want 1/0/1/0", out_e, busy_e, if_e.tx_ready, st_e);
    end
    @(negedge clk); reset = 1'b1;
    for (int c = 0; c < 3 * FL; c++) begin
      @(negedge clk);
      total++; if (out_e !== 1'b1 || busy_e !== 1'b0 || if_e.tx_ready !== 1'b1) begin
        bad++; $display("FAIL rst_idle c=%0d: got out=%b busy=%b rdy=%b want 1/0/1", c, out_e, busy_e, if_e.tx_ready);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    total = 0;
    bad   = 0;
    if_e.tx_data = 8'h00; if_e.tx_valid = 1'b0;
    if_o.tx_data = 8'h00; if_o.tx_valid = 1'b0;
    if_s.tx_data = 8'h00; if_s.tx_valid = 1'b0;
    test_reset();
    test_frame_33();
    test_parity();
    test_back_to_back();
    test_slow_baud();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
